// File: rtl/pmem_loader.sv
// Program-memory loader: assembles 12-bit instructions from a framed byte
// stream and writes them to the program memory load port.
// Frame: HEADER, N, N x {H, L}, CS. N == 0 means 256 instructions.
module pmem_loader #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        LoadE,
    output logic [7:0]  LoadAddr,
    output logic [11:0] LoadInstruction,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StCsum
    } state_e;

    state_e      r_state;
    logic [8:0]  r_remaining;
    logic [7:0]  r_acc;
    logic [3:0]  r_hi;
    logic        r_in_ready;
    logic        r_load_e;
    logic [7:0]  r_load_addr;
    logic [11:0] r_load_instr;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_accept;

    // A byte transfers only when the registered ready is high; rst masks it.
    assign w_accept = in_valid && r_in_ready && !rst;

    assign in_ready        = r_in_ready && !rst;
    assign LoadE           = r_load_e;
    assign LoadAddr        = r_load_addr;
    assign LoadInstruction = r_load_instr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_remaining  <= 9'd0;
            r_acc        <= 8'd0;
            r_hi         <= 4'd0;
            r_in_ready   <= 1'b1;
            r_load_e     <= 1'b0;
            r_load_addr  <= BASE_ADDR;
            r_load_instr <= 12'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept && in_data == HEADER) begin
                        r_state     <= StCount;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_acc       <= 8'd0;
                        r_load_addr <= BASE_ADDR;
                    end
                end
                StCount: begin
                    if (w_accept) begin
                        // N == 0 encodes a full 256-instruction frame.
                        r_remaining <= {(in_data == 8'd0), in_data};
                        r_state     <= StHi;
                    end
                end
                StHi: begin
                    if (w_accept) begin
                        if (in_data[7:4] != 4'd0) begin
                            r_state <= StIdle;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_hi    <= in_data[3:0];
                            r_acc   <= r_acc + in_data;
                            r_state <= StLo;
                        end
                    end
                end
                StLo: begin
                    if (w_accept) begin
                        r_load_instr <= {r_hi, in_data};
                        r_acc        <= r_acc + in_data;
                        r_remaining  <= r_remaining - 9'd1;
                        r_load_e     <= 1'b1;
                        r_in_ready   <= 1'b0;
                        r_state      <= StWrite;
                    end
                end
                StWrite: begin
                    // One-cycle bubble; address advances after the strobe.
                    r_load_e    <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_load_addr <= r_load_addr + 8'd1;
                    r_state     <= (r_remaining == 9'd0) ? StCsum : StHi;
                end
                StCsum: begin
                    if (w_accept) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        if (in_data == r_acc) begin
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
